// File: rtl/alu_seq_if.sv
// Operation types and the request/result bundle for the sequential ALU.
// The control package lives here so the interface and the core share one definition.
package control;
   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_ROL,
      OP_SHR, OP_ROR, OP_AND, OP_OR, OP_XOR, OP_NOT
   } alu_op_e;

   typedef enum logic [1:0] {
      FLAG_NONE, FLAG_ZERO, FLAG_CARRY, FLAG_REM
   } alu_flag_e;
endpackage

interface alu_seq_if #(parameter int DATA_WIDTH = 8);
   logic                    start_i;
   control::alu_op_e        op_i;
   control::alu_flag_e      flag_sel_i;
   logic [DATA_WIDTH-1:0]   a_i;
   logic [DATA_WIDTH-1:0]   b_i;
   logic                    busy_o;
   logic                    done_o;
   logic [DATA_WIDTH-1:0]   result_o;
   logic                    flag_o;

   modport master (
      output start_i, op_i, flag_sel_i, a_i, b_i,
      input  busy_o, done_o, result_o, flag_o
   );

   modport slave (
      input  start_i, op_i, flag_sel_i, a_i, b_i,
      output busy_o, done_o, result_o, flag_o
   );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Define ALU_SEQ_MULDIV_EN to build the iterative datapath; otherwise MUL/DIV return zero in one cycle.
module alu_seq #(
   parameter int DATA_WIDTH = 8
) (
   input logic      clk,
   input logic      rst,
   alu_seq_if.slave bus
);
   import control::*;

   localparam int W = DATA_WIDTH;

`ifdef ALU_SEQ_MULDIV_EN
   localparam int CW = $clog2(W + 1);
   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;
`else
   typedef enum logic [1:0] {S_IDLE, S_DONE} state_e;
`endif

   state_e         state_q, state_d;
   logic           load_single;
   logic [W-1:0]   s_res;
   logic           s_carry;
   logic [W-1:0]   result_q;
   logic           flag_q;

   function automatic logic sel_flag(input alu_flag_e fs, input alu_op_e op,
                                     input logic [W-1:0] r, input logic c,
                                     input logic remnz);
      case (fs)
         FLAG_ZERO:  return (r == '0);
         FLAG_CARRY: return c;
         FLAG_REM:   return (op == OP_DIV) && remnz;
         default:    return 1'b0;
      endcase
   endfunction

`ifdef ALU_SEQ_MULDIV_EN
   logic           load_iter, iter_last, is_iter;
   alu_op_e        op_q;
   alu_flag_e      fsel_q;
   logic [W-1:0]   a_q, b_q;
   // hi/lo hold {partial product, multiplier} for MUL and {remainder, dividend} for DIV
   logic [W-1:0]   hi_q, lo_q, hi_d, lo_d;
   logic [CW-1:0]  cnt_q;
   logic [W:0]     m_sum, d_sh;
   logic [W-1:0]   d_sub;
   logic           it_carry, it_remnz;

   assign is_iter = (bus.op_i == OP_MUL) || ((bus.op_i == OP_DIV) && (bus.b_i != '0));

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      m_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
      d_sh  = {hi_q, lo_q[W-1]};
      d_sub = d_sh[W-1:0] - b_q;
      if (op_q == OP_MUL) begin
         hi_d = m_sum[W:1];
         lo_d = {m_sum[0], lo_q[W-1:1]};
      end else if (d_sh >= {1'b0, b_q}) begin
         hi_d = d_sub;
         lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
         hi_d = d_sh[W-1:0];
         lo_d = {lo_q[W-2:0], 1'b0};
      end
   end

   assign it_carry = (op_q == OP_MUL) && (hi_d != '0);
   assign it_remnz = (op_q == OP_DIV) && (hi_d != '0);
`endif

   always_comb begin
      s_res   = '0;
      s_carry = 1'b0;
      case (bus.op_i)
         OP_ADD: {s_carry, s_res} = {1'b0, bus.a_i} + {1'b0, bus.b_i};
         OP_SUB: begin
            s_res   = bus.a_i - bus.b_i;
            s_carry = (bus.a_i < bus.b_i);
         end
`ifdef ALU_SEQ_MULDIV_EN
         OP_DIV: if (bus.b_i == '0) begin
            s_res   = '1;
            s_carry = 1'b1;
         end
`endif
         OP_SHL: begin s_res = {bus.a_i[W-2:0], 1'b0};          s_carry = bus.a_i[W-1]; end
         OP_ROL: begin s_res = {bus.a_i[W-2:0], bus.a_i[W-1]};  s_carry = bus.a_i[W-1]; end
         OP_SHR: begin s_res = {1'b0, bus.a_i[W-1:1]};          s_carry = bus.a_i[0];   end
         OP_ROR: begin s_res = {bus.a_i[0], bus.a_i[W-1:1]};    s_carry = bus.a_i[0];   end
         OP_AND: s_res = bus.a_i & bus.b_i;
         OP_OR:  s_res = bus.a_i | bus.b_i;
         OP_XOR: s_res = bus.a_i ^ bus.b_i;
         OP_NOT: s_res = ~bus.a_i;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      load_single = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      load_iter   = 1'b0;
      iter_last   = 1'b0;
`endif
      case (state_q)
         S_IDLE: if (bus.start_i) begin
`ifdef ALU_SEQ_MULDIV_EN
            if (is_iter) begin
               state_d   = S_ITER;
               load_iter = 1'b1;
            end else begin
               state_d     = S_DONE;
               load_single = 1'b1;
            end
`else
            state_d     = S_DONE;
            load_single = 1'b1;
`endif
         end
`ifdef ALU_SEQ_MULDIV_EN
         S_ITER: if (cnt_q == CW'(W - 1)) begin
            state_d   = S_DONE;
            iter_last = 1'b1;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         flag_q   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
         op_q     <= OP_ADD;
         fsel_q   <= FLAG_NONE;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         if (load_single) begin
            result_q <= s_res;
            flag_q   <= sel_flag(bus.flag_sel_i, bus.op_i, s_res, s_carry, 1'b0);
         end
`ifdef ALU_SEQ_MULDIV_EN
         if (load_iter) begin
            op_q   <= bus.op_i;
            fsel_q <= bus.flag_sel_i;
            a_q    <= bus.a_i;
            b_q    <= bus.b_i;
            hi_q   <= '0;
            lo_q   <= (bus.op_i == OP_MUL) ? bus.b_i : bus.a_i;
            cnt_q  <= '0;
         end
         if (state_q == S_ITER) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= iter_last ? '0 : cnt_q + CW'(1);
         end
         // the final step's combinational value is the answer, so it lands with the DONE transition
         if (iter_last) begin
            result_q <= lo_d;
            flag_q   <= sel_flag(fsel_q, op_q, lo_d, it_carry, it_remnz);
         end
`endif
      end
   end

   assign bus.busy_o   = (state_q != S_IDLE);
   assign bus.done_o   = (state_q == S_DONE);
   assign bus.result_o = result_q;
   assign bus.flag_o   = flag_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against an arithmetic reference model.
// Follows ALU_SEQ_MULDIV_EN the same way the design does.
module tb_alu_seq;
   import control::*;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;

   alu_seq_if #(.DATA_WIDTH(8)) bus ();

   alu_seq #(.DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference: plain integer arithmetic on 8-bit values
   function automatic void model(input alu_op_e op, input alu_flag_e fs, input int a, input int b,
                                 output int res, output int fl, output int lat);
      int c, rz;
      res = 0; c = 0; rz = 0; lat = 1;
      case (op)
         OP_ADD: begin res = (a + b) % 256; c = ((a + b) > 255); end
         OP_SUB: begin res = (a - b + 256) % 256; c = (a < b); end
`ifdef ALU_SEQ_MULDIV_EN
         OP_MUL: begin res = (a * b) % 256; c = ((a * b) / 256 != 0); lat = 9; end
         OP_DIV: if (b == 0) begin res = 255; c = 1; end
                 else begin res = a / b; rz = (a % b != 0); lat = 9; end
`endif
         OP_SHL: begin res = (a * 2) % 256;           c = a / 128; end
         OP_ROL: begin res = (a * 2) % 256 + a / 128; c = a / 128; end
         OP_SHR: begin res = a / 2;                   c = a % 2;   end
         OP_ROR: begin res = a / 2 + (a % 2) * 128;   c = a % 2;   end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = 255 - a;
         default: ;
      endcase
      case (fs)
         FLAG_ZERO:  fl = (res == 0);
         FLAG_CARRY: fl = c;
         FLAG_REM:   fl = (op == OP_DIV) ? rz : 0;
         default:    fl = 0;
      endcase
   endfunction

   // Called just after a falling edge; returns just after a falling edge with the DUT idle.
   task automatic run_op(input alu_op_e op, input alu_flag_e fs, input int a, input int b,
                         input int inject, input bit poke);
      int res, fl, exp_lat, lat, busy_n;
      model(op, fs, a, b, res, fl, exp_lat);
      bus.start_i = 1'b1; bus.op_i = op; bus.flag_sel_i = fs;
      bus.a_i = 8'(a); bus.b_i = 8'(b);
      @(posedge clk); #1;
      bus.start_i    = 1'b0;
      bus.a_i        = 8'($urandom);
      bus.b_i        = 8'($urandom);
      bus.op_i       = alu_op_e'($urandom_range(0, 11));
      bus.flag_sel_i = alu_flag_e'($urandom_range(0, 3));
      lat = 0; busy_n = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (bus.busy_o) busy_n++;
         if (inject != 0 && lat == inject) begin
            bus.start_i = 1'b1; bus.op_i = OP_ADD; bus.a_i = 8'd1; bus.b_i = 8'd1;
         end else bus.start_i = 1'b0;
         if (bus.done_o || lat > 40) break;
      end
      chk("latency", lat, exp_lat);
      chk("busy_cycles", busy_n, exp_lat);
      chk("result", int'(bus.result_o), res);
      chk("flag", int'(bus.flag_o), fl);
      if (poke) begin
         bus.start_i = 1'b1; bus.op_i = OP_NOT; bus.a_i = 8'd0;
      end
      @(negedge clk);
      bus.start_i = 1'b0;
      chk("done_pulse", int'(bus.done_o), 0);
      chk("idle_busy", int'(bus.busy_o), 0);
      chk("result_hold", int'(bus.result_o), res);
   endtask

   initial begin
      int seen;
      n_chk = 0; n_pass = 0;
      rst = 1'b1;
      bus.start_i = 1'b0; bus.op_i = OP_ADD; bus.flag_sel_i = FLAG_NONE;
      bus.a_i = '0; bus.b_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(bus.busy_o), 0);
      chk("rst_done", int'(bus.done_o), 0);
      chk("rst_result", int'(bus.result_o), 0);
      chk("rst_flag", int'(bus.flag_o), 0);

      // first start lands on the first edge after reset release
      rst = 1'b0;
      run_op(OP_ADD, FLAG_CARRY, 'hF0, 'h20, 0, 1'b0);
      run_op(OP_MUL, FLAG_CARRY, 'h13, 'h11, 0, 1'b0);
      run_op(OP_DIV, FLAG_REM,   'h64, 'h07, 0, 1'b0);
      run_op(OP_DIV, FLAG_CARRY, 'h05, 'h00, 0, 1'b0);
      run_op(OP_DIV, FLAG_REM,   'h05, 'h00, 0, 1'b0);
      run_op(OP_ROR, FLAG_CARRY, 'h01, 'h00, 0, 1'b0);
      run_op(OP_XOR, FLAG_ZERO,  'h5A, 'h5A, 0, 1'b1);
      run_op(OP_MUL, FLAG_ZERO,  'h03, 'h04, 0, 1'b1);
      run_op(OP_SUB, FLAG_CARRY, 'h00, 'h01, 0, 1'b0);
      run_op(OP_ADD, FLAG_REM,   'hFF, 'hFF, 0, 1'b0);
      run_op(OP_DIV, FLAG_ZERO,  'h03, 'h07, 0, 1'b0);
      run_op(OP_MUL, FLAG_NONE,  'hFF, 'hFF, 0, 1'b0);
      // start pulsed mid-MUL must not be taken or queued
      run_op(OP_MUL, FLAG_CARRY, 'h13, 'h11, 3, 1'b0);

      // reset mid-MUL aborts with cleared outputs and no done
      bus.start_i = 1'b1; bus.op_i = OP_MUL; bus.flag_sel_i = FLAG_CARRY;
      bus.a_i = 8'h13; bus.b_i = 8'h11;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort_busy", int'(bus.busy_o), 0);
      chk("abort_done", int'(bus.done_o), 0);
      chk("abort_result", int'(bus.result_o), 0);
      chk("abort_flag", int'(bus.flag_o), 0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done_o) seen = 1;
      end
      chk("abort_no_done", seen, 0);

      for (int i = 0; i < 300; i++) begin
         int a, b;
         a = $urandom_range(0, 255);
         b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
         run_op(alu_op_e'($urandom_range(0, 11)), alu_flag_e'($urandom_range(0, 3)),
                a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
                1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
